// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Bundles the control FSM's datapath-facing signals.
//   master : the control FSM (samples opcode/memReady, drives all selects,
//            strobes and the debug state)
//   slave  : the datapath side (drives opcode/memReady, consumes controls)
// Signals:
//   opcode[5:0]   instruction[31:26] from the instruction register
//   memReady      memory completed the current access this cycle
//   aluOP[1:0]    00 add, 01 subtract, 10 use funct
//   aluSrcA       0=PC, 1=register A
//   aluSrcB[1:0]  00=B, 01=4, 10=sext imm, 11=sext imm<<2
//   pcSrc[1:0]    00=ALU result, 01=ALUOut, 10=jump address
//   pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
//   memToReg, regWrite, regDst, illegalOp, state[3:0]
// ---------------------------------------------------------------------------
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       memReady;
    logic [1:0] aluOP;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regWrite;
    logic       regDst;
    logic       illegalOp;
    logic [3:0] state;

    modport master (
        input  opcode, memReady,
        output aluOP, aluSrcA, aluSrcB, pcSrc, pcWrite, pcWriteCond, iorD,
               memRead, memWrite, irWrite, memToReg, regWrite, regDst,
               illegalOp, state
    );

    modport slave (
        output opcode, memReady,
        input  aluOP, aluSrcA, aluSrcB, pcSrc, pcWrite, pcWriteCond, iorD,
               memRead, memWrite, irWrite, memToReg, regWrite, regDst,
               illegalOp, state
    );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multicycle MIPS datapath. Walks each instruction
// through fetch/decode/execute/memory/writeback and Moore-decodes every mux
// select and write strobe from the current state; memory states stall on
// memReady.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (state -> RESET_STATE, strobes 0)
//   bus    multicycle_control_if.master (opcode/memReady in, controls out)
// Parameters:
//   RESET_STATE  state entered on reset (FETCH)
// Configuration macro:
//   MULTICYCLE_CTRL_ADDI_EN  builds the ADDIEX/ADDIWB path for addi (001000);
//                            when undefined addi is reported as illegal.
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_control_if.master   bus
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
`ifdef MULTICYCLE_CTRL_ADDI_EN
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
`endif

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    logic [3:0] state_r;
    logic [3:0] next_s;

    logic [1:0] alu_op_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] pc_src_s;
    logic       pc_write_s;
    logic       pc_write_cond_s;
    logic       iord_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       mem_to_reg_s;
    logic       reg_write_s;
    logic       reg_dst_s;
    logic       illegal_s;

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; opcode is only looked at in DECODE and MEMADR.
    always_comb begin
        next_s = S_FETCH;
        case (state_r)
            S_FETCH:  next_s = bus.memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: next_s = S_MEMADR;
                    OP_RTYPE:     next_s = S_EXEC;
                    OP_BEQ:       next_s = S_BRANCH;
                    OP_J:         next_s = S_JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
                    OP_ADDI:      next_s = S_ADDIEX;
`endif
                    default:      next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.opcode == OP_LW) begin
                    next_s = S_MEMRD;
                end else if (bus.opcode == OP_SW) begin
                    next_s = S_MEMWR;
                end else begin
                    // opcode no longer a memory op: abandon safely
                    next_s = S_FETCH;
                end
            end
            S_MEMRD:  next_s = bus.memReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_s = S_FETCH;
            S_MEMWR:  next_s = bus.memReady ? S_FETCH : S_MEMWR;
            S_EXEC:   next_s = S_ALUWB;
            S_ALUWB:  next_s = S_FETCH;
            S_BRANCH: next_s = S_FETCH;
            S_JUMP:   next_s = S_FETCH;
`ifdef MULTICYCLE_CTRL_ADDI_EN
            S_ADDIEX: next_s = S_ADDIWB;
            S_ADDIWB: next_s = S_FETCH;
`endif
            default:  next_s = S_FETCH;
        endcase
    end

    // Moore output decode (illegal pulse depends on opcode while in DECODE).
    always_comb begin
        alu_op_s        = 2'b00;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = 2'b00;
        pc_src_s        = 2'b00;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        iord_s          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_write_s     = 1'b0;
        reg_dst_s       = 1'b0;
        illegal_s       = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                // IR load and PC+4 commit only once the fetch completes
                ir_write_s  = bus.memReady;
                pc_write_s  = bus.memReady;
            end
            S_DECODE: begin
                alu_src_b_s = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: illegal_s = 1'b0;
`ifdef MULTICYCLE_CTRL_ADDI_EN
                    OP_ADDI: illegal_s = 1'b0;
`endif
                    default: illegal_s = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = 2'b01;
                pc_src_s        = 2'b01;
                pc_write_cond_s = 1'b1;
            end
            S_JUMP: begin
                pc_src_s   = 2'b10;
                pc_write_s = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_ADDI_EN
            S_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
            end
`endif
            default: begin
                alu_op_s = 2'b00;
            end
        endcase
    end

    // Selects pass straight through; strobes are killed combinationally
    // while rst_n is low so nothing is written after a reset edge.
    assign bus.aluOP       = alu_op_s;
    assign bus.aluSrcA     = alu_src_a_s;
    assign bus.aluSrcB     = alu_src_b_s;
    assign bus.pcSrc       = pc_src_s;
    assign bus.iorD        = iord_s;
    assign bus.memToReg    = mem_to_reg_s;
    assign bus.regDst      = reg_dst_s;
    assign bus.pcWrite     = pc_write_s      & rst_n;
    assign bus.pcWriteCond = pc_write_cond_s & rst_n;
    assign bus.memRead     = mem_read_s      & rst_n;
    assign bus.memWrite    = mem_write_s     & rst_n;
    assign bus.irWrite     = ir_write_s      & rst_n;
    assign bus.regWrite    = reg_write_s     & rst_n;
    assign bus.illegalOp   = illegal_s       & rst_n;
    assign bus.state       = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    multicycle_control_if bus ();

    multicycle_control #(.RESET_STATE(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {pcWrite, pcWriteCond, memRead, memWrite, irWrite, regWrite, illegalOp}
    logic [6:0] strobes;
    assign strobes = {bus.pcWrite, bus.pcWriteCond, bus.memRead, bus.memWrite,
                      bus.irWrite, bus.regWrite, bus.illegalOp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.memReady = 1'b1;
        bus.opcode = 6'b000000;
        #12;
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", bus.state); end
        tests++; if (strobes !== 7'b0000000) begin fails++; $display("FAIL reset_strobes got %b exp 0000000", strobes); end
        tests++; if (bus.aluSrcB !== 2'b01) begin fails++; $display("FAIL reset_alusrcb got %b exp 01", bus.aluSrcB); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++; if (strobes !== 7'b1010100) begin fails++; $display("FAIL fetch_strobes got %b exp 1010100", strobes); end
        tick();
        tests++; if (bus.state !== 4'd1) begin fails++; $display("FAIL fetch_to_decode got %0d exp 1", bus.state); end
        // leave via jump so each later test starts in FETCH
        bus.opcode = 6'b000010;
        #1;
        tick();
        tests++; if (bus.state !== 4'd9 || bus.pcWrite !== 1'b1 || bus.pcSrc !== 2'b10)
            begin fails++; $display("FAIL jump got st=%0d pw=%b ps=%b exp 9 1 10", bus.state, bus.pcWrite, bus.pcSrc); end
        tick();
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL jump_return got %0d exp 0", bus.state); end
    endtask

    task automatic test_lw;
        bus.opcode = 6'b100011;
        bus.memReady = 1'b1;
        tick();
        tests++; if (bus.state !== 4'd1 || bus.aluSrcB !== 2'b11) begin fails++; $display("FAIL lw_decode got st=%0d b=%b exp 1 11", bus.state, bus.aluSrcB); end
        tick();
        tests++; if (bus.state !== 4'd2 || bus.aluSrcA !== 1'b1 || bus.aluSrcB !== 2'b10)
            begin fails++; $display("FAIL lw_memadr got st=%0d a=%b b=%b exp 2 1 10", bus.state, bus.aluSrcA, bus.aluSrcB); end
        tick();
        bus.opcode = 6'b000100; // ignored from here on
        #1;
        tests++; if (bus.state !== 4'd3 || bus.memRead !== 1'b1 || bus.iorD !== 1'b1)
            begin fails++; $display("FAIL lw_memrd got st=%0d mr=%b iord=%b exp 3 1 1", bus.state, bus.memRead, bus.iorD); end
        tick();
        tests++; if (bus.state !== 4'd4 || bus.regWrite !== 1'b1 || bus.memToReg !== 1'b1 || bus.regDst !== 1'b0)
            begin fails++; $display("FAIL lw_memwb got st=%0d rw=%b m2r=%b rd=%b exp 4 1 1 0", bus.state, bus.regWrite, bus.memToReg, bus.regDst); end
        tick();
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL lw_return got %0d exp 0", bus.state); end
    endtask

    task automatic test_sw_stall;
        bus.opcode = 6'b101011;
        tick();
        tick();
        bus.memReady = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tests++; if (bus.state !== 4'd5 || bus.memWrite !== 1'b1 || bus.iorD !== 1'b1 || bus.regWrite !== 1'b0)
                begin fails++; $display("FAIL sw_wait%0d got st=%0d mw=%b iord=%b rw=%b exp 5 1 1 0", i, bus.state, bus.memWrite, bus.iorD, bus.regWrite); end
            tick();
        end
        tests++; if (bus.state !== 4'd5) begin fails++; $display("FAIL sw_hold got %0d exp 5", bus.state); end
        bus.memReady = 1'b1;
        tick();
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL sw_return got %0d exp 0", bus.state); end
        // fetch stall: no IR/PC write while memory not ready
        bus.memReady = 1'b0;
        #1;
        tests++; if (strobes !== 7'b0010000) begin fails++; $display("FAIL fetch_stall_strobes got %b exp 0010000", strobes); end
        tick();
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL fetch_stall_state got %0d exp 0", bus.state); end
        bus.memReady = 1'b1;
        #1;
    endtask

    task automatic test_rtype_beq;
        bus.opcode = 6'b000000;
        tick();
        tick();
        tests++; if (bus.state !== 4'd6 || bus.aluOP !== 2'b10 || bus.aluSrcA !== 1'b1 || bus.aluSrcB !== 2'b00)
            begin fails++; $display("FAIL exec got st=%0d op=%b a=%b b=%b exp 6 10 1 00", bus.state, bus.aluOP, bus.aluSrcA, bus.aluSrcB); end
        tick();
        tests++; if (bus.state !== 4'd7 || bus.regWrite !== 1'b1 || bus.regDst !== 1'b1 || bus.memToReg !== 1'b0)
            begin fails++; $display("FAIL aluwb got st=%0d rw=%b rd=%b m2r=%b exp 7 1 1 0", bus.state, bus.regWrite, bus.regDst, bus.memToReg); end
        tick();
        bus.opcode = 6'b000100;
        tick();
        tick();
        tests++; if (bus.state !== 4'd8 || bus.aluOP !== 2'b01 || bus.pcWriteCond !== 1'b1 || bus.pcSrc !== 2'b01 || bus.pcWrite !== 1'b0)
            begin fails++; $display("FAIL branch got st=%0d op=%b pwc=%b ps=%b pw=%b exp 8 01 1 01 0", bus.state, bus.aluOP, bus.pcWriteCond, bus.pcSrc, bus.pcWrite); end
        tick();
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL branch_return got %0d exp 0", bus.state); end
    endtask

    task automatic test_illegal_addi;
        bus.opcode = 6'b111111;
        tick();
        tests++; if (bus.state !== 4'd1 || bus.illegalOp !== 1'b1) begin fails++; $display("FAIL illegal_pulse got st=%0d ill=%b exp 1 1", bus.state, bus.illegalOp); end
        tick();
        tests++; if (bus.state !== 4'd0 || bus.illegalOp !== 1'b0) begin fails++; $display("FAIL illegal_return got st=%0d ill=%b exp 0 0", bus.state, bus.illegalOp); end
        bus.opcode = 6'b001000;
        tick();
`ifdef MULTICYCLE_CTRL_ADDI_EN
        tests++; if (bus.illegalOp !== 1'b0) begin fails++; $display("FAIL addi_decode got ill=%b exp 0", bus.illegalOp); end
        tick();
        tests++; if (bus.state !== 4'd10 || bus.aluSrcA !== 1'b1 || bus.aluSrcB !== 2'b10)
            begin fails++; $display("FAIL addiex got st=%0d a=%b b=%b exp 10 1 10", bus.state, bus.aluSrcA, bus.aluSrcB); end
        tick();
        tests++; if (bus.state !== 4'd11 || bus.regWrite !== 1'b1 || bus.regDst !== 1'b0)
            begin fails++; $display("FAIL addiwb got st=%0d rw=%b rd=%b exp 11 1 0", bus.state, bus.regWrite, bus.regDst); end
        tick();
`else
        tests++; if (bus.illegalOp !== 1'b1) begin fails++; $display("FAIL addi_illegal got ill=%b exp 1", bus.illegalOp); end
        tick();
`endif
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL addi_return got %0d exp 0", bus.state); end
    endtask

    task automatic test_reset_abort;
        bus.opcode = 6'b100011;
        tick();
        tick();
        bus.memReady = 1'b0;
        tick();
        tests++; if (bus.state !== 4'd3 || bus.memRead !== 1'b1) begin fails++; $display("FAIL abort_pre got st=%0d mr=%b exp 3 1", bus.state, bus.memRead); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL abort_state got %0d exp 0", bus.state); end
        tests++; if (strobes !== 7'b0000000) begin fails++; $display("FAIL abort_strobes got %b exp 0000000", strobes); end
        bus.memReady = 1'b1;
        tick();
        tests++; if (bus.state !== 4'd0 || strobes !== 7'b0000000) begin fails++; $display("FAIL abort_held got st=%0d str=%b exp 0 0000000", bus.state, strobes); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++; if (bus.state !== 4'd1) begin fails++; $display("FAIL abort_restart got %0d exp 1", bus.state); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_rtype_beq();
        test_illegal_addi();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
